// File: rtl/pipe_add_pkg.sv
// Shared sizing constants for the pipelined adder/subtractor.
package pipe_add_pkg;

    localparam int unsigned DEF_WIDTH  = 32'd16;
    localparam int unsigned DEF_STAGES = 32'd4;

    function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational N-bit ripple adder built from per-bit full adders.
module add_slice #(
    parameter int unsigned N = 32'd4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic ci_s;
        logic co_s;
        if (i == 0) begin : g_lsb
            assign ci_s = cin;
        end else begin : g_chain
            assign ci_s = g_fa[i-1].co_s;
        end
        assign s[i] = a[i] ^ b[i] ^ ci_s;
        assign co_s = (a[i] & b[i]) | (ci_s & (a[i] ^ b[i]));
    end

    assign cout = g_fa[N-1].co_s;
    assign cmsb = g_fa[N-1].ci_s;

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/subtract: one SLICE-bit ripple segment per stage, operands skewed
// forward and finished sum slices carried along so a whole result exits together.
module pipe_add_sub
    import pipe_add_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned SLICE = slice_width(WIDTH, STAGES);

    logic advance_s;

    // The whole pipe moves as one; it only freezes when a finished result is refused.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic             vld_in_s;
        logic             c_in_s;
        logic [WIDTH-1:0] a_in_s;
        logic [WIDTH-1:0] b_in_s;
        logic [WIDTH-1:0] sum_in_s;
        logic [WIDTH-1:0] sum_nxt_s;
        logic [SLICE-1:0] s_s;
        logic             cout_s;
        logic             cmsb_s;
        logic             vld_r;
        logic             cy_r;
        logic [WIDTH-1:0] sum_r;

        if (k == 0) begin : g_head
            // Subtraction folds into the adder as a + ~b + 1.
            assign vld_in_s = in_valid;
            assign a_in_s   = a;
            assign b_in_s   = sub ? ~b : b;
            assign c_in_s   = sub ? 1'b1 : cin;
            assign sum_in_s = {WIDTH{1'b0}};
        end else begin : g_body
            assign vld_in_s = g_stg[k-1].vld_r;
            assign a_in_s   = g_stg[k-1].g_skew.a_r;
            assign b_in_s   = g_stg[k-1].g_skew.b_r;
            assign c_in_s   = g_stg[k-1].cy_r;
            assign sum_in_s = g_stg[k-1].sum_r;
        end

        add_slice #(.N(SLICE)) u_slice (
            .a    (a_in_s[k*SLICE +: SLICE]),
            .b    (b_in_s[k*SLICE +: SLICE]),
            .cin  (c_in_s),
            .s    (s_s),
            .cout (cout_s),
            .cmsb (cmsb_s)
        );

        // Merge this stage's slice into the partial result travelling with it.
        always_comb begin
            sum_nxt_s                    = sum_in_s;
            sum_nxt_s[k*SLICE +: SLICE] = s_s;
        end

        // Stage valid, carry and partial-sum registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                cy_r  <= 1'b0;
                sum_r <= {WIDTH{1'b0}};
            end else if (advance_s) begin
                vld_r <= vld_in_s;
                cy_r  <= cout_s;
                sum_r <= sum_nxt_s;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic             unused_s;

            assign unused_s = cmsb_s;

            // Operand skew registers feeding the next stage's slice.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= {WIDTH{1'b0}};
                    b_r <= {WIDTH{1'b0}};
                end else if (advance_s) begin
                    a_r <= a_in_s;
                    b_r <= b_in_s;
                end
            end
        end else begin : g_tail
            logic unused_s;

            assign unused_s = ^{a_in_s, b_in_s};

            // Signed overflow from the carries around the MSB of the final slice.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf <= 1'b0;
                end else if (advance_s) begin
                    ovf <= cmsb_s ^ cout_s;
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].vld_r;
    assign sum       = g_stg[STAGES-1].sum_r;
    assign co        = g_stg[STAGES-1].cy_r;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Random and directed checks of pipe_add_sub at several STAGES settings against a
// plain-arithmetic reference model with per-instance expected-result queues.
module tb_pipe_add_sub;

    localparam int NS = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             cin;
    logic             sub;
    logic [NS-1:0]    ir;
    logic [NS-1:0]    ov;
    logic [NS-1:0]    co_o;
    logic [NS-1:0]    ovf_o;
    logic [15:0]      sum_o [NS];
    logic [3:0]       sum4;

    int checks   = 0;
    int failures = 0;

    logic [17:0]   q [NS][$];
    logic [NS-1:0] held_vld;
    logic [17:0]   held [NS];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pipe_add_sub #(
            .WIDTH  (16),
            .STAGES ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .sum       (sum_o[g]),
            .co        (co_o[g]),
            .ovf       (ovf_o[g])
        );
    end

    pipe_add_sub #(.WIDTH(4), .STAGES(1)) u_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir[4]),
        .a         (a[3:0]),
        .b         (b[3:0]),
        .cin       (cin),
        .sub       (sub),
        .out_valid (ov[4]),
        .out_ready (out_ready),
        .sum       (sum4),
        .co        (co_o[4]),
        .ovf       (ovf_o[4])
    );

    assign sum_o[4] = {12'h000, sum4};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {co, ovf, sum} from integer arithmetic on w-bit operands.
    function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                          input logic tc, input logic ts, input int w);
        int mask, ua, ub, bb, full, sa, sb, res;
        logic c, v;
        mask = (1 << w) - 1;
        ua   = int'(ta) & mask;
        ub   = int'(tb) & mask;
        bb   = ts ? (~ub & mask) : ub;
        full = ua + bb + (ts ? 1 : int'(tc));
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        res  = ts ? sa - sb : sa + sb + int'(tc);
        v    = (res > (1 << (w - 1)) - 1) || (res < -(1 << (w - 1)));
        c    = ((full >> w) & 1) != 0;
        return {c, v, 16'(full & mask)};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: sampled on the falling edge, between input changes and the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) q[i].delete();
            held_vld <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                check_eq("rdy_rule", 32'(ir[i]), 32'(!ov[i] || out_ready));
                if (held_vld[i] && ov[i])
                    check_eq("hold_stable", {14'd0, co_o[i], ovf_o[i], sum_o[i]}, {14'd0, held[i]});
                held_vld[i] <= ov[i] && !out_ready;
                held[i]     <= {co_o[i], ovf_o[i], sum_o[i]};
                if (ov[i] && out_ready) begin
                    check_eq("expected_out", 32'(q[i].size() != 0), 32'd1);
                    if (q[i].size() != 0)
                        check_eq("result", {14'd0, co_o[i], ovf_o[i], sum_o[i]}, {14'd0, q[i].pop_front()});
                end
                if (in_valid && ir[i])
                    q[i].push_back(model(a, b, cin, sub, (i == 4) ? 4 : 16));
            end
        end
    end

    task automatic send_one(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                            input logic ts, input int idx, input int lat,
                            input logic [17:0] expv, input string tag);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!ov[idx] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(lat));
        check_eq({tag, "_val"}, {14'd0, co_o[idx], ovf_o[idx], sum_o[idx]}, {14'd0, expv});
    endtask

    initial begin
        int acc, ret;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
        #12;
        for (int i = 0; i < NS; i++) begin
            check_eq("rst_out", {13'd0, ov[i], co_o[i], ovf_o[i], sum_o[i]}, 32'd0);
            check_eq("rst_rdy", 32'(ir[i]), 32'd1);
        end
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) check_eq("rdy_after_rst", 32'(ir[i]), 32'd1);

        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 2, 4, 18'h18000, "add_ovf");
        send_one(16'h0005, 16'h0007, 1'b1, 1'b1, 2, 4, 18'h0FFFE, "sub_neg");
        send_one(16'h8000, 16'h0001, 1'b1, 1'b1, 2, 4, 18'h37FFF, "sub_ovf");
        send_one(16'h0007, 16'h0008, 1'b1, 1'b0, 4, 1, 18'h20000, "w4_carry");
        send_one(16'h0007, 16'h0008, 1'b0, 1'b0, 4, 1, 18'h0000F, "w4_nocarry");
        repeat (20) @(posedge clk);

        // Eight back-to-back operand sets with a three-cycle consumer stall.
        acc = 0; ret = 0;
        for (int c = 0; c < 40 && ret < 8; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 6 && c < 9);
            if (acc < 8) begin
                in_valid = 1'b1; a = pick(); b = pick();
                cin = 1'($urandom); sub = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && ir[2]) acc++;
            if (c >= 6 && c < 9) check_eq("hold_rdy", 32'(ir[2]), 32'd0);
            if (c >= 9 && ret < 8) check_eq("no_gap", 32'(ov[2]), 32'd1);
            if (ov[2] && out_ready) ret++;
        end
        check_eq("stream_cnt", 32'(ret), 32'd8);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);

        // Reset with three transactions in flight.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_valid", 32'(ov[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {13'd0, ov[2], co_o[2], ovf_o[2], sum_o[2]}, 32'd0);
        check_eq("rst_async_rdy", 32'(ir[2]), 32'd1);
        @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check_eq("no_stale", 32'(ov[2]), 32'd0);
        end
        send_one(16'h1234, 16'h0F0F, 1'b0, 1'b0, 2, 4, 18'h02143, "post_rst");
        repeat (20) @(posedge clk);

        // Random operands, random input bubbles and random consumer stalls.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 8);
            a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) check_eq("drained", 32'(q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_add_sub.md
PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits, at least 2.
REQ-002 Parameter STAGES, default 4: number of pipeline stages, 1..WIDTH; WIDTH SHALL be a multiple of STAGES; SLICE = WIDTH/STAGES.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: an operand set is presented this cycle.
REQ-006 Port in_ready, output, 1: the block accepts the operand set this cycle.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port cin, input, 1: carry-in; used only when sub=0.
REQ-010 Port sub, input, 1: 0 selects a+b+cin; 1 selects a-b.
REQ-011 Port out_valid, output, 1: result on sum/co/ovf is valid.
REQ-012 Port out_ready, input, 1: the consumer accepts the result this cycle.
REQ-013 Port sum, output, WIDTH: result modulo 2^WIDTH.
REQ-014 Port co, output, 1: carry-out of the MSB; for sub=1 it means "no borrow".
REQ-015 Port ovf, output, 1: two's-complement signed overflow of the result.

Function
REQ-016 Transfer on input SHALL occur when in_valid and in_ready are both 1; transfer on output SHALL occur when out_valid and out_ready are both 1.
REQ-017 sub=1 SHALL compute a + ~b + 1, with cin ignored; sub=0 SHALL compute a + b + cin.
REQ-018 Stage k (0..STAGES-1) SHALL add bits [k*SLICE +: SLICE] using the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-019 Upper operand slices SHALL be skewed through registers, and completed lower sum slices SHALL be delayed, so that all WIDTH bits of one transaction emerge together.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, computed in the last stage.
REQ-021 Latency SHALL be exactly STAGES cycles from an input transfer to out_valid, with no stalls.
REQ-022 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-023 Each stage SHALL carry a valid bit; bubbles SHALL propagate without corrupting adjacent transactions.
REQ-024 Stall rule: advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational); when advance=0 every stage register SHALL hold its contents.
REQ-025 While out_valid=1 and out_ready=0, sum, co and ovf SHALL remain stable.
REQ-026 Transactions SHALL retire in acceptance order, with no loss or duplication.
REQ-027 When a transfer is accepted and the output retires in the same cycle, both SHALL take effect.
REQ-028 With STAGES=1 the block SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-029 When rst_n=0, all valid bits SHALL clear asynchronously; out_valid=0, sum=0, co=0 and ovf=0.
REQ-030 In-flight transactions SHALL be discarded on reset, with no partial result emitted.
REQ-031 in_ready SHALL be 1 during and immediately after reset.
REQ-032 Data registers other than the outputs need no reset.

Structure
REQ-033 The default WIDTH/STAGES constants and the SLICE derivation SHALL reside in the shared package pipe_add_pkg.
REQ-034 The sub-module add_slice (parameter N) SHALL be a combinational N-bit ripple adder built from per-bit full adders by a generate loop, with outputs s, cout and the MSB carry-in.
REQ-035 pipe_add_sub SHALL instantiate STAGES add_slice instances by a generate loop.

Verification
REQ-036 WIDTH=16, STAGES=4: a=0x7FFF, b=0x0001, sub=0, cin=0 -> after 4 cycles sum=0x8000, co=0, ovf=1.
REQ-037 WIDTH=16, STAGES=4: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, co=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, co=1, ovf=1.
REQ-038 Stream 8 back-to-back transactions and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the hold, outputs stable, all 8 results in order, no gaps once out_ready=1.
REQ-039 Assert rst_n=0 with 3 transactions in flight -> out_valid falls immediately, no stale result after release, the next transaction has a clean latency of 4.
REQ-040 WIDTH=4, STAGES=1: a=7, b=8, cin=1, sub=0 -> next cycle sum=0, co=1, ovf=0; a=7, b=8, cin=0 -> sum=15, co=0.
REQ-041 Randomised run of 10000 transactions with random stalls, WIDTH=16, STAGES in {1,2,4,16}, compared with a reference model -> zero mismatches.
